// File: rtl/uart_fifo_core.sv
// uart_fifo_core: buffered UART with TX/RX FIFOs, runtime baud divisor and sticky error flags.
// Optional parity bit and parity_err flag are built only when UART_PARITY_EN is defined.
module uart_fifo_core #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 9_600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned TX_DEPTH  = 16,
    parameter int unsigned RX_DEPTH  = 16
`ifdef UART_PARITY_EN
    ,
    parameter int unsigned PARITY_ODD = 0
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      write_en,
    input  logic [7:0]                write_data,
    input  logic                      read_en,
    output logic [31:0]               read_data,
    input  logic                      div_we,
    input  logic [15:0]               div_data,
    input  logic                      err_clr,
    output logic                      tx_full,
    output logic                      tx_busy,
    output logic                      rx_empty,
    output logic [$clog2(RX_DEPTH):0] rx_count,
`ifdef UART_PARITY_EN
    output logic [3:0]                err_flags,
`else
    output logic [2:0]                err_flags,
`endif
    input  logic                      uart_rx,
    output logic                      uart_tx
);
    localparam int unsigned TAW = $clog2(TX_DEPTH);
    localparam int unsigned RAW = $clog2(RX_DEPTH);
    localparam logic [15:0] RST_DIV = 16'((CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE);
    localparam logic [TAW:0] TX_FULL_CNT = (TAW + 1)'(TX_DEPTH);
    localparam logic [RAW:0] RX_FULL_CNT = (RAW + 1)'(RX_DEPTH);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

`ifdef UART_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [15:0] div_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         div_reg <= RST_DIV;
        else if (div_we) div_reg <= (div_data < 16'd2) ? 16'd2 : div_data;
    end

    // ---------------- TX FIFO + engine ----------------
    logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
    logic [TAW-1:0]       tx_wr_ptr, tx_rd_ptr;
    logic [TAW:0]         tx_count;
    logic [DATA_BITS-1:0] tx_head, tx_shift;
    state_t               tx_state;
    logic [16:0]          tx_cnt, tx_bit_lim, tx_stop_lim;
    logic [15:0]          tx_div;
    logic [3:0]           tx_bit;
    logic                 tx_frame_end, tx_pop, tx_push, tx_ovf_evt;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    assign tx_head      = tx_mem[tx_rd_ptr];
    assign tx_bit_lim   = {1'b0, tx_div} - 17'd1;
    assign tx_stop_lim  = (STOP_BITS == 2) ? ({tx_div, 1'b0} - 17'd1) : tx_bit_lim;
    assign tx_frame_end = (tx_state == STOP) && (tx_cnt == tx_stop_lim);
    // Popping in the last stop cycle lets the next start bit follow with no idle gap.
    assign tx_pop       = (tx_count != '0) && ((tx_state == IDLE) || tx_frame_end);
    assign tx_push      = write_en && ((tx_count != TX_FULL_CNT) || tx_pop);
    assign tx_ovf_evt   = write_en && !tx_push;
    assign tx_full      = (tx_count == TX_FULL_CNT);
    assign tx_busy      = (tx_count != '0) || (tx_state != IDLE);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= write_data[DATA_BITS-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
            else if (tx_pop && !tx_push) tx_count <= tx_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= IDLE;
            uart_tx  <= 1'b1;
            tx_cnt   <= '0;
            tx_div   <= RST_DIV;
            tx_bit   <= '0;
            tx_shift <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            if (tx_state != IDLE) tx_cnt <= tx_cnt + 17'd1;
            if (tx_pop) begin
                tx_state <= START;
                uart_tx  <= 1'b0;
                tx_cnt   <= '0;
                tx_div   <= div_reg;
                tx_shift <= tx_head;
`ifdef UART_PARITY_EN
                tx_par   <= (^tx_head) ^ PAR_ODD;
`endif
            end else begin
                case (tx_state)
                    IDLE: ;
                    START: if (tx_cnt == tx_bit_lim) begin
                        tx_state <= DATA;
                        uart_tx  <= tx_shift[0];
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                    end
                    DATA: if (tx_cnt == tx_bit_lim) begin
                        tx_cnt <= '0;
                        if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            tx_state <= PARITY;
                            uart_tx  <= tx_par;
`else
                            tx_state <= STOP;
                            uart_tx  <= 1'b1;
`endif
                        end else begin
                            tx_bit   <= tx_bit + 4'd1;
                            tx_shift <= tx_shift >> 1;
                            uart_tx  <= tx_shift[1];
                        end
                    end
`ifdef UART_PARITY_EN
                    PARITY: if (tx_cnt == tx_bit_lim) begin
                        tx_state <= STOP;
                        uart_tx  <= 1'b1;
                        tx_cnt   <= '0;
                    end
`endif
                    STOP: if (tx_frame_end) tx_state <= IDLE;
                    default: tx_state <= IDLE;
                endcase
            end
        end
    end

    // ---------------- RX synchroniser, engine + FIFO ----------------
    // rx_s1/rx_s2 form the synchroniser; rx_s3 only holds history for edge detection.
    logic rx_s1, rx_s2, rx_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
    logic [RAW-1:0]       rx_wr_ptr, rx_rd_ptr;
    logic [DATA_BITS-1:0] rx_shift;
    state_t               rx_state;
    logic [16:0]          rx_cnt, rx_bit_lim, rx_half_lim;
    logic [15:0]          rx_div;
    logic [3:0]           rx_bit;
    logic                 rx_stop_sample, rx_frame_evt, rx_good, rx_pop, rx_push, rx_ovr_evt;

    assign rx_bit_lim     = {1'b0, rx_div} - 17'd1;
    assign rx_half_lim    = {2'b0, rx_div[15:1]} - 17'd1;
    assign rx_stop_sample = (rx_state == STOP) && (rx_cnt == rx_bit_lim);
    assign rx_frame_evt   = rx_stop_sample && !rx_s2;
`ifdef UART_PARITY_EN
    logic rx_par_bit, rx_par_evt;
    assign rx_par_evt = rx_stop_sample && rx_s2 && (((^rx_shift) ^ rx_par_bit) != PAR_ODD);
    assign rx_good    = rx_stop_sample && rx_s2 && !rx_par_evt;
`else
    assign rx_good    = rx_stop_sample && rx_s2;
`endif
    assign rx_pop     = read_en && (rx_count != '0);
    assign rx_push    = rx_good && ((rx_count != RX_FULL_CNT) || rx_pop);
    assign rx_ovr_evt = rx_good && !rx_push;
    assign rx_empty   = (rx_count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_div   <= RST_DIV;
            rx_bit   <= '0;
            rx_shift <= '0;
`ifdef UART_PARITY_EN
            rx_par_bit <= 1'b0;
`endif
        end else begin
            if (rx_state != IDLE) rx_cnt <= rx_cnt + 17'd1;
            case (rx_state)
                IDLE: if (rx_s3 && !rx_s2) begin
                    rx_state <= START;
                    rx_cnt   <= '0;
                    rx_div   <= div_reg;
                end
                START: if (rx_cnt == rx_half_lim) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? IDLE : DATA;
                end
                DATA: if (rx_cnt == rx_bit_lim) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                    rx_bit   <= rx_bit + 4'd1;
`ifdef UART_PARITY_EN
                    if (rx_bit == LAST_BIT) rx_state <= PARITY;
`else
                    if (rx_bit == LAST_BIT) rx_state <= STOP;
`endif
                end
`ifdef UART_PARITY_EN
                PARITY: if (rx_cnt == rx_bit_lim) begin
                    rx_cnt     <= '0;
                    rx_par_bit <= rx_s2;
                    rx_state   <= STOP;
                end
`endif
                STOP: if (rx_stop_sample) rx_state <= IDLE;
                default: rx_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            read_data <= '1;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
            else if (rx_pop && !rx_push) rx_count <= rx_count - 1'b1;
            if (read_en)
                read_data <= rx_pop ? {{(32 - DATA_BITS){1'b0}}, rx_mem[rx_rd_ptr]} : '1;
        end
    end

    // A new event in the err_clr cycle wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_flags <= '0;
`ifdef UART_PARITY_EN
        else err_flags <= (err_clr ? 4'b0 : err_flags) | {rx_par_evt, rx_frame_evt, rx_ovr_evt, tx_ovf_evt};
`else
        else err_flags <= (err_clr ? 3'b0 : err_flags) | {rx_frame_evt, rx_ovr_evt, tx_ovf_evt};
`endif
    end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Self-checking bench for uart_fifo_core at div=10, 8N1, TX_DEPTH=4, RX_DEPTH=2.
`timescale 1ns/1ps
module tb_uart_fifo_core;
    localparam int DIV = 10;

    logic        clk = 1'b0, rst = 1'b1;
    logic        write_en = 1'b0, read_en = 1'b0, div_we = 1'b0, err_clr = 1'b0;
    logic [7:0]  write_data = '0;
    logic [15:0] div_data = '0;
    logic [31:0] read_data;
    logic        tx_full, tx_busy, rx_empty;
    logic [1:0]  rx_count;
    logic [2:0]  err_flags;
    logic        uart_rx, uart_tx;
    logic        loop = 1'b0, rx_drv = 1'b1;

    int checks = 0;
    int failures = 0;

    assign uart_rx = loop ? uart_tx : rx_drv;
    always #5 clk = ~clk;

    uart_fifo_core #(
        .CLK_FREQ (1_000_000),
        .BAUD_RATE(100_000),
        .DATA_BITS(8),
        .STOP_BITS(1),
        .TX_DEPTH (4),
        .RX_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .write_en  (write_en),
        .write_data(write_data),
        .read_en   (read_en),
        .read_data (read_data),
        .div_we    (div_we),
        .div_data  (div_data),
        .err_clr   (err_clr),
        .tx_full   (tx_full),
        .tx_busy   (tx_busy),
        .rx_empty  (rx_empty),
        .rx_count  (rx_count),
        .err_flags (err_flags),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx)
    );

    // Line monitor: one uart_tx sample per cycle, taken at the falling clock edge.
    logic txs[$];
    always @(negedge clk) txs.push_back(uart_tx);

    typedef struct {
        logic [7:0]  data;
        logic [9:0]  frame;   // bit i = i-th transmitted bit (start, d0..d7, stop)
        logic [31:0] rd;
    } vec_t;
    vec_t vecs[6];

    logic [7:0] mq[$];
    logic       m_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        write_en = 1'b1; write_data = b; tick(); write_en = 1'b0;
    endtask

    task automatic read_word();
        read_en = 1'b1; tick(); read_en = 1'b0;
    endtask

    task automatic set_div(input logic [15:0] d);
        div_we = 1'b1; div_data = d; tick(); div_we = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
    endtask

    task automatic wait_tx_idle(input int limit);
        int n = 0;
        while (tx_busy && n < limit) begin tick(); n++; end
        if (tx_busy) begin
            checks++; failures++;
            $display("FAIL tx idle timeout: busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_v);
        rx_drv = 1'b0; tick(DIV);
        for (int i = 0; i < 8; i++) begin rx_drv = b[i]; tick(DIV); end
        rx_drv = stop_v; tick(DIV);
        rx_drv = 1'b1;
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // Finds the next start bit from pos and checks every bit period holds its level for div samples.
    task automatic decode_frame(input string tag, input logic [9:0] exp, input int div,
                                inout int pos, output int gap);
        int ones;
        gap = 0;
        while (pos < txs.size() && txs[pos] !== 1'b0) begin pos++; gap++; end
        if (pos + 10 * div > txs.size()) begin
            checks++; failures++;
            $display("FAIL %s frame: got %0d samples required %0d", tag, txs.size() - pos, 10 * div);
            return;
        end
        for (int k = 0; k < 10; k++) begin
            ones = 0;
            for (int c = 0; c < div; c++) begin
                if (txs[pos] === 1'b1) ones++;
                pos++;
            end
            check($sformatf("%s bit%0d high-samples", tag, k), ones, exp[k] ? div : 0);
        end
    endtask

    initial begin
        int pos, gap, n, zeros, nreads;
        logic [7:0]  b;
        logic [31:0] exp_rd;

        vecs[0] = '{8'hA5, 10'h34A, 32'h0000_00A5};
        vecs[1] = '{8'h00, 10'h200, 32'h0000_0000};
        vecs[2] = '{8'hFF, 10'h3FE, 32'h0000_00FF};
        vecs[3] = '{8'h3C, 10'h278, 32'h0000_003C};
        vecs[4] = '{8'hC3, 10'h386, 32'h0000_00C3};
        vecs[5] = '{8'h81, 10'h302, 32'h0000_0081};

        // Reset state
        tick(3);
        rst = 1'b0;
        tick();
        check("reset uart_tx", uart_tx, 1);
        check("reset read_data", read_data, 32'hFFFF_FFFF);
        check("reset tx_full", tx_full, 0);
        check("reset tx_busy", tx_busy, 0);
        check("reset rx_empty", rx_empty, 1);
        check("reset rx_count", rx_count, 0);
        check("reset err_flags", err_flags, 0);

        // Single TX: start latency, bit timing, busy release after the stop bit
        txs.delete();
        write_byte(8'hA5);
        n = 0;
        while (uart_tx !== 1'b0 && n < 20) begin tick(); n++; end
        check("single tx start latency", n, 1);
        n = 0;
        while (tx_busy && n < 200) begin tick(); n++; end
        check("single tx busy cycles from start", n, 100);
        pos = 0;
        decode_frame("single A5", 10'h34A, DIV, pos, gap);

        // Table vectors through loopback: TX frame shape and received word
        loop = 1'b1;
        foreach (vecs[i]) begin
            txs.delete();
            write_byte(vecs[i].data);
            wait_tx_idle(300);
            tick(2);
            check($sformatf("vec%0d rx_count", i), rx_count, 1);
            pos = 0;
            decode_frame($sformatf("vec%0d", i), vecs[i].frame, DIV, pos, gap);
            read_word();
            check($sformatf("vec%0d read_data", i), read_data, vecs[i].rd);
        end
        loop = 1'b0;

        // Burst of 7 strobes into a 4-deep FIFO; last one shares its cycle with err_clr
        txs.delete();
        for (int i = 0; i < 7; i++) begin
            write_en = 1'b1;
            write_data = 8'(8'h11 * (i + 1));
            err_clr = (i == 6);
            tick();
        end
        write_en = 1'b0; err_clr = 1'b0;
        check("burst tx_full", tx_full, 1);
        check("burst overflow survives same-cycle clear", err_flags, 3'b001);
        clear_err();
        check("burst err_clr", err_flags, 0);
        wait_tx_idle(800);
        pos = 0;
        for (int i = 0; i < 5; i++) begin
            decode_frame($sformatf("burst%0d", i), frame_of(8'(8'h11 * (i + 1))), DIV, pos, gap);
            if (i > 0) check($sformatf("burst%0d idle gap", i), gap, 0);
        end
        zeros = 0;
        for (int i = pos; i < txs.size(); i++) if (txs[i] === 1'b0) zeros++;
        check("burst no extra frame", zeros, 0);

        // Divisor change mid-frame, then clamp of a zero divisor
        txs.delete();
        write_byte(8'h96);
        tick(30);
        set_div(16'd20);
        write_byte(8'h69);
        wait_tx_idle(600);
        pos = 0;
        decode_frame("div old frame", frame_of(8'h96), 10, pos, gap);
        decode_frame("div new frame", frame_of(8'h69), 20, pos, gap);
        check("div new frame gap", gap, 0);
        set_div(16'd0);
        txs.delete();
        write_byte(8'hE7);
        wait_tx_idle(100);
        pos = 0;
        decode_frame("div clamp", frame_of(8'hE7), 2, pos, gap);
        set_div(16'd10);

        // Loopback of two bytes, then read past empty
        loop = 1'b1;
        write_byte(8'h3C);
        write_byte(8'hC3);
        wait_tx_idle(500);
        tick(2);
        loop = 1'b0;
        check("loop rx_count", rx_count, 2);
        check("loop rx_empty", rx_empty, 0);
        read_word();
        check("loop read 1", read_data, 32'h0000_003C);
        tick(3);
        check("loop read_data hold", read_data, 32'h0000_003C);
        read_word();
        check("loop read 2", read_data, 32'h0000_00C3);
        read_word();
        check("loop read empty", read_data, 32'hFFFF_FFFF);
        check("loop rx_empty after", rx_empty, 1);

        // Glitch shorter than half a bit
        rx_drv = 1'b0; tick(3); rx_drv = 1'b1;
        tick(30);
        check("glitch rx_count", rx_count, 0);
        check("glitch err_flags", err_flags, 0);

        // Framing error
        send_rx(8'h5A, 1'b0);
        tick(5);
        check("frame err_flags", err_flags, 3'b100);
        check("frame rx_count", rx_count, 0);
        clear_err();
        check("frame err_clr", err_flags, 0);

        // Overrun on a 2-deep RX FIFO with back-to-back frames
        send_rx(8'hA1, 1'b1);
        send_rx(8'hB2, 1'b1);
        send_rx(8'hC3, 1'b1);
        tick(5);
        check("overrun err_flags", err_flags, 3'b010);
        check("overrun rx_count", rx_count, 2);
        read_word();
        check("overrun read 1", read_data, 32'h0000_00A1);
        read_word();
        check("overrun read 2", read_data, 32'h0000_00B2);
        read_word();
        check("overrun read empty", read_data, 32'hFFFF_FFFF);
        clear_err();

        // Randomized RX traffic against a queue model
        m_ovr = 1'b0;
        for (int it = 0; it < 12; it++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1);
            if (mq.size() < 2) mq.push_back(b);
            else m_ovr = 1'b1;
            tick(2);
            nreads = $urandom_range(0, 2);
            for (int r = 0; r < nreads; r++) begin
                exp_rd = (mq.size() > 0) ? {24'h0, mq.pop_front()} : 32'hFFFF_FFFF;
                read_word();
                check($sformatf("rand%0d read", it), read_data, exp_rd);
            end
            check($sformatf("rand%0d rx_count", it), rx_count, mq.size());
            check($sformatf("rand%0d err_flags", it), err_flags, {1'b0, m_ovr, 1'b0});
        end
        while (mq.size() > 0) begin
            exp_rd = {24'h0, mq.pop_front()};
            read_word();
            check("rand drain read", read_data, exp_rd);
        end
        clear_err();

        // Randomized TX frames against the frame model
        for (int it = 0; it < 4; it++) begin
            b = 8'($urandom);
            txs.delete();
            write_byte(b);
            wait_tx_idle(300);
            pos = 0;
            decode_frame($sformatf("rand tx%0d", it), frame_of(b), DIV, pos, gap);
        end

        // Reset during TX data bit 3 with RX data pending
        send_rx(8'h5E, 1'b1);
        send_rx(8'hE5, 1'b1);
        read_word();
        check("pre-reset read", read_data, 32'h0000_005E);
        write_byte(8'hA5);
        tick(46);
        check("pre-reset uart_tx bit3", uart_tx, 0);
        check("pre-reset tx_busy", tx_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async reset uart_tx", uart_tx, 1);
        check("async reset tx_busy", tx_busy, 0);
        check("async reset rx_empty", rx_empty, 1);
        check("async reset rx_count", rx_count, 0);
        check("async reset read_data", read_data, 32'hFFFF_FFFF);
        check("async reset err_flags", err_flags, 0);
        tick(2);
        rst = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL global timeout: simulation still running, required completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_fifo_core.md
Name: uart_fifo_core

Overview:
- Second-generation UART peripheral on the CPU memory-mapped bus.
- Buffered transmitter and receiver with parametrised data/stop bits and FIFO depths.
- Runtime-programmable baud divisor; sticky overflow/overrun/framing error flags.
- Drop-in for the CPU UART slot: same strobe-style write/read interface, plus status outputs.

Parameters:
- CLK_FREQ, 100_000_000, clock frequency in Hz
- BAUD_RATE, 9_600, reset baud; reset divisor = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE
- DATA_BITS, 8, data bits per frame, legal range 5..8
- STOP_BITS, 1, stop bits per frame, 1 or 2
- TX_DEPTH, 16, TX FIFO entries, power of 2, minimum 2
- RX_DEPTH, 16, RX FIFO entries, power of 2, minimum 2

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- write_en  in  1  1-cycle strobe: push write_data[DATA_BITS-1:0] to TX FIFO
- write_data  in  8  TX byte; unused upper bits ignored
- read_en  in  1  1-cycle strobe: pop RX FIFO
- read_data  out  32  registered pop result
- div_we  in  1  strobe: load div_data into the divisor register
- div_data  in  16  new baud divisor; values < 2 are clamped to 2
- err_clr  in  1  strobe: clear all sticky error flags
- tx_full  out  1  TX FIFO full
- tx_busy  out  1  TX FIFO non-empty or frame in progress
- rx_empty  out  1  RX FIFO empty
- rx_count  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy
- err_flags  out  3  sticky flags: {frame_err, rx_overrun, tx_overflow}
- uart_rx  in  1  serial input, asynchronous
- uart_tx  out  1  serial output, idles high

Behaviour:
- Reset (asynchronous):
  - uart_tx=1, read_data=32'hFFFF_FFFF.
  - FIFOs empty: tx_full=0, tx_busy=0, rx_empty=1, rx_count=0.
  - err_flags=0; divisor = reset divisor.
  - RX 2-flop synchroniser resets to 1.
  - Any frame in progress is abandoned; uart_tx goes high immediately.
- Divisor:
  - Each engine latches the divisor at its frame start.
  - div_we mid-frame affects only later frames.
- TX FIFO:
  - write_en while full: data dropped, tx_overflow set.
  - write_en while full with a same-cycle engine pop: write accepted.
- TX engine states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: when FIFO non-empty, pop the head; uart_tx drives start bit (0) from the next cycle.
  - Every bit is held exactly div cycles.
  - DATA: LSB first, DATA_BITS bits.
  - STOP: STOP_BITS*div cycles high.
  - Back-to-back: the next frame's start bit begins the cycle after the last stop cycle; no idle gap.
- RX synchroniser: 2 flops; all RX logic uses the synchronised signal.
- RX engine states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling edge (1->0) on the synchronised line enters START.
  - START: re-sample at div/2 cycles; if high, it is a glitch -> IDLE with no flag.
  - DATA: sample each data bit div cycles after the previous sample (mid-bit), LSB first.
  - STOP: sample the first stop bit only.
    - Low: set frame_err, discard byte.
    - High: push byte to RX FIFO; if FIFO full, set rx_overrun and drop byte.
  - After STOP, return to IDLE at the sample point, so a following start edge is caught.
- RX pop:
  - read_en with FIFO non-empty: next cycle read_data = {24'h0, byte zero-extended from DATA_BITS}.
  - read_en with FIFO empty: next cycle read_data = 32'hFFFF_FFFF, state unchanged.
  - read_data holds its value when read_en is low.
  - Push on a full FIFO with a same-cycle pop: push accepted, count unchanged, no overrun.
- FIFO pointers wrap modulo depth; count is depth+1 wide, so full is distinguishable from empty.
- Sticky flags:
  - err_clr clears all flags.
  - A new error in the same cycle as err_clr leaves that flag set.
- Parity: absent unless UART_PARITY_EN is defined.

Optional Feature:
- Macro UART_PARITY_EN. When defined:
  - Adds parameter PARITY_ODD (default 0).
  - TX inserts one parity bit after the data bits: even parity when PARITY_ODD=0, odd when 1.
  - RX checks the parity bit; on mismatch the byte is discarded.
  - err_flags widens to 4: {parity_err, frame_err, rx_overrun, tx_overflow}.
- When undefined: no parity bit, err_flags is 3 bits, no parity logic is synthesised.

Test Plan:
- Setup for all scenarios: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (div=10), DATA_BITS=8, STOP_BITS=1.
- Single TX: write 8'hA5 -> uart_tx low for 10 cycles, then bits 1,0,1,0,0,1,0,1 each 10 cycles, then high 10 cycles; tx_busy falls after the stop bit.
- TX burst/overflow (TX_DEPTH=4): 6 write strobes in 6 cycles -> 5 accepted (1 popped immediately, 4 queued), 1 dropped, tx_overflow=1; 5 frames back-to-back with no gap.
- RX loopback with uart_tx tied to uart_rx, sending 8'h3C, 8'hC3 -> rx_count=2; read_en twice -> read_data 32'h0000003C then 32'h000000C3; third read -> 32'hFFFF_FFFF.
- Glitch and framing:
  - 3-cycle low pulse on uart_rx -> no push, no flags.
  - Frame with stop bit low -> frame_err=1, rx_count unchanged.
  - err_clr -> err_flags=0.
- Overrun and divisor change:
  - RX_DEPTH=2, receive 3 bytes -> rx_overrun=1, FIFO holds first two bytes.
  - div_we with div_data=20 mid-TX-frame -> current frame stays 10 cycles/bit, next frame 20 cycles/bit.
- Reset mid-frame: assert rst during TX data bit 3 -> uart_tx=1 in the same cycle, tx_busy=0, rx_empty=1, read_data=32'hFFFF_FFFF.
